// File: rtl/gcd_harness_pkg.sv
// Shared types and elaboration-time helpers for the GCD key harness.
// Contents: state_e controller state, num_pages() LED paging helper,
// cnt_w() counter width helper, default counter widths.
package gcd_harness_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    SHOW  = 2'd3
  } state_e;

  localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int unsigned DEF_TIMEOUT_CYC  = 50_000_000;
  localparam int unsigned DEF_DEB_CNT_W    = 32'($clog2(DEF_DEBOUNCE_CYC));
  localparam int unsigned DEF_TMO_CNT_W    = 32'($clog2(DEF_TIMEOUT_CYC));

  // Number of LED_W-wide pages needed to show a data_w-bit result.
  function automatic int unsigned num_pages(input int unsigned data_w,
                                            input int unsigned led_w);
    return (data_w + led_w - 32'd1) / led_w;
  endfunction

  // Width of a counter that runs 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key debouncer: 2-flop synchronizer, stability counter, press pulse.
// Ports:
//   clock    in  system clock
//   reset_n  in  async active-low reset (debounced level resets to released)
//   i_key_n  in  raw active-low key, asynchronous to clock
//   o_press  out one-cycle pulse after the debounced level goes 1->0
module key_debounce
  import gcd_harness_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int unsigned        CNT_W   = cnt_w(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYC - 32'd1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // Level follows the synced key only after DEBOUNCE_CYC consecutive differing samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/gcd_key_harness.sv
// Board-side front end for a GCD engine: debounced start/page keys, one
// valid/ready request per start press, latched result paged onto LEDs.
// Optional feature macro: GCD_HARNESS_TIMEOUT_EN (WAIT-state timeout).
// Ports:
//   clock, reset_n            system clock, async active-low reset
//   key_start_n, key_page_n   raw active-low buttons
//   op_x, op_y                DATA_W operands, sampled on accepted start
//   gcd_input_*               request channel to engine (valid/ready)
//   gcd_output_valid/bits     engine result
//   led                       result slice, or all ones on error
//   busy                      request in flight (ISSUE or WAIT)
//   err                       both operands zero, or timeout; sticky until next start
module gcd_key_harness
  import gcd_harness_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned GCD_W        = 32,
  parameter int unsigned LED_W        = 4,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned TIMEOUT_CYC  = 50_000_000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              key_start_n,
  input  logic              key_page_n,
  input  logic [DATA_W-1:0] op_x,
  input  logic [DATA_W-1:0] op_y,
  input  logic              gcd_input_ready,
  output logic              gcd_input_valid,
  output logic [GCD_W-1:0]  gcd_input_bits_x,
  output logic [GCD_W-1:0]  gcd_input_bits_y,
  input  logic              gcd_output_valid,
  input  logic [GCD_W-1:0]  gcd_output_bits,
  output logic [LED_W-1:0]  led,
  output logic              busy,
  output logic              err
);

  localparam int unsigned      NUM_PAGES = num_pages(DATA_W, LED_W);
  localparam int unsigned      PAGE_W    = cnt_w(NUM_PAGES);
  localparam int unsigned      DISP_W    = NUM_PAGES * LED_W;
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_PAGES - 32'd1);

  if (DATA_W > GCD_W || LED_W == 0 || DEBOUNCE_CYC == 0 || TIMEOUT_CYC == 0) begin : g_bad_param
    $error("gcd_key_harness: illegal parameter combination");
  end

  logic w_start;
  logic w_page;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_start (
    .clock   (clock),
    .reset_n (reset_n),
    .i_key_n (key_start_n),
    .o_press (w_start)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_page (
    .clock   (clock),
    .reset_n (reset_n),
    .i_key_n (key_page_n),
    .o_press (w_page)
  );

  state_e              r_state;
  logic                r_valid;
  logic [GCD_W-1:0]    r_x;
  logic [GCD_W-1:0]    r_y;
  logic [GCD_W-1:0]    r_result;
  logic [PAGE_W-1:0]   r_page;
  logic                r_err;
  logic [LED_W-1:0]    r_led;
  logic                r_busy;

  state_e              w_state_nxt;
  logic                w_valid_nxt;
  logic [GCD_W-1:0]    w_x_nxt;
  logic [GCD_W-1:0]    w_y_nxt;
  logic [GCD_W-1:0]    w_result_nxt;
  logic [PAGE_W-1:0]   w_page_nxt;
  logic                w_err_nxt;
  logic [LED_W-1:0]    w_led_nxt;
  logic                w_busy_nxt;
  logic [DISP_W-1:0]   w_disp;

`ifdef GCD_HARNESS_TIMEOUT_EN
  localparam int unsigned     TMO_W   = cnt_w(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC - 32'd1);
  logic [TMO_W-1:0] r_tcnt;
  logic [TMO_W-1:0] w_tcnt_nxt;
`endif

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_result <= '0;
      r_page   <= '0;
      r_err    <= 1'b0;
      r_led    <= '0;
      r_busy   <= 1'b0;
`ifdef GCD_HARNESS_TIMEOUT_EN
      r_tcnt   <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_valid  <= w_valid_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_result <= w_result_nxt;
      r_page   <= w_page_nxt;
      r_err    <= w_err_nxt;
      r_led    <= w_led_nxt;
      r_busy   <= w_busy_nxt;
`ifdef GCD_HARNESS_TIMEOUT_EN
      r_tcnt   <= w_tcnt_nxt;
`endif
    end
  end

  // Next-state, request and display logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = r_valid;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_result_nxt = r_result;
    w_page_nxt   = r_page;
    w_err_nxt    = r_err;
`ifdef GCD_HARNESS_TIMEOUT_EN
    w_tcnt_nxt   = r_tcnt;
`endif

    case (r_state)
      IDLE, SHOW: begin
        // Start has priority over a coincident page press.
        if (w_start) begin
          w_x_nxt    = GCD_W'(op_x);
          w_y_nxt    = GCD_W'(op_y);
          w_err_nxt  = 1'b0;
          w_page_nxt = '0;
          if (op_x != '0 && op_y != '0) begin
            w_state_nxt = ISSUE;
            w_valid_nxt = 1'b1;
          end else if (op_x == '0 && op_y == '0) begin
            w_result_nxt = '0;
            w_err_nxt    = 1'b1;
            w_state_nxt  = SHOW;
          end else begin
            // gcd(0, n) = n; the engine never sees a zero operand.
            w_result_nxt = (op_x == '0) ? GCD_W'(op_y) : GCD_W'(op_x);
            w_state_nxt  = SHOW;
          end
        end else if (w_page && r_state == SHOW) begin
          w_page_nxt = (r_page == PAGE_LAST) ? '0 : r_page + PAGE_W'(1);
        end
      end
      ISSUE: begin
        if (r_valid && gcd_input_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = WAIT;
`ifdef GCD_HARNESS_TIMEOUT_EN
          w_tcnt_nxt  = '0;
`endif
        end
      end
      WAIT: begin
        if (gcd_output_valid) begin
          w_result_nxt = gcd_output_bits;
          w_page_nxt   = '0;
          w_state_nxt  = SHOW;
`ifdef GCD_HARNESS_TIMEOUT_EN
        end else if (r_tcnt == TMO_MAX) begin
          w_result_nxt = '0;
          w_err_nxt    = 1'b1;
          w_page_nxt   = '0;
          w_state_nxt  = SHOW;
        end else begin
          w_tcnt_nxt = r_tcnt + TMO_W'(1);
`endif
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase

    // Result padded to a whole number of pages; the top page is zero-filled.
    w_disp     = DISP_W'(w_result_nxt);
    w_led_nxt  = w_err_nxt ? {LED_W{1'b1}}
                           : LED_W'(w_disp >> (32'(w_page_nxt) * LED_W));
    w_busy_nxt = (w_state_nxt == ISSUE) || (w_state_nxt == WAIT);
  end

  assign gcd_input_valid  = r_valid;
  assign gcd_input_bits_x = r_x;
  assign gcd_input_bits_y = r_y;
  assign led              = r_led;
  assign busy             = r_busy;
  assign err              = r_err;

endmodule

// File: tb/tb_gcd_key_harness.sv
// Directed bench for gcd_key_harness with a small engine model
// (configurable ready delay and response latency).
module tb_gcd_key_harness;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned GCD_W  = 32;
  localparam int unsigned LED_W  = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              key_start_n = 1'b1;
  logic              key_page_n = 1'b1;
  logic [DATA_W-1:0] op_x = '0;
  logic [DATA_W-1:0] op_y = '0;
  logic              gcd_input_ready = 1'b0;
  logic              gcd_input_valid;
  logic [GCD_W-1:0]  gcd_input_bits_x;
  logic [GCD_W-1:0]  gcd_input_bits_y;
  logic              gcd_output_valid = 1'b0;
  logic [GCD_W-1:0]  gcd_output_bits = '0;
  logic [LED_W-1:0]  led;
  logic              busy;
  logic              err;

  gcd_key_harness #(
    .DATA_W(DATA_W), .GCD_W(GCD_W), .LED_W(LED_W),
    .DEBOUNCE_CYC(4), .TIMEOUT_CYC(16)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .key_start_n      (key_start_n),
    .key_page_n       (key_page_n),
    .op_x             (op_x),
    .op_y             (op_y),
    .gcd_input_ready  (gcd_input_ready),
    .gcd_input_valid  (gcd_input_valid),
    .gcd_input_bits_x (gcd_input_bits_x),
    .gcd_input_bits_y (gcd_input_bits_y),
    .gcd_output_valid (gcd_output_valid),
    .gcd_output_bits  (gcd_output_bits),
    .led              (led),
    .busy             (busy),
    .err              (err)
  );

  always #5 clock = ~clock;

  int n_err = 0;
  int n_chk = 0;

  // Engine model state
  int          eng_ready_delay = 0;
  int          eng_latency = 0;
  bit          eng_respond = 1'b1;
  int          n_req = 0;
  int          n_valid_cyc = 0;
  int          n_stall = 0;
  int          n_unstable = 0;
  int          vcnt = 0;
  int          lat = 0;
  bit          pending = 1'b0;
  logic [31:0] got_x = '0;
  logic [31:0] got_y = '0;
  logic [31:0] prev_x = '0;
  logic [31:0] prev_y = '0;
  logic [31:0] resp_val = '0;

  function automatic logic [31:0] gcd_f(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = b;
      b = a % b;
      a = t;
    end
    return a;
  endfunction

  // Engine: drives ready/response on the falling edge, DUT samples on the rising edge.
  always @(negedge clock) begin
    gcd_output_valid = 1'b0;
    if (pending) begin
      if (lat == 0) begin
        gcd_output_valid = 1'b1;
        gcd_output_bits  = resp_val;
        pending          = 1'b0;
      end else begin
        lat = lat - 1;
      end
    end
    if (gcd_input_valid === 1'b1) begin
      n_valid_cyc++;
      if (vcnt > 0 && (gcd_input_bits_x !== prev_x || gcd_input_bits_y !== prev_y))
        n_unstable++;
      prev_x = gcd_input_bits_x;
      prev_y = gcd_input_bits_y;
      if (vcnt < eng_ready_delay) begin
        gcd_input_ready = 1'b0;
        n_stall++;
      end else begin
        gcd_input_ready = 1'b1;
        n_req++;
        got_x    = gcd_input_bits_x;
        got_y    = gcd_input_bits_y;
        resp_val = gcd_f(gcd_input_bits_x, gcd_input_bits_y);
        pending  = eng_respond;
        lat      = eng_latency;
      end
      vcnt++;
    end else begin
      gcd_input_ready = 1'b0;
      vcnt = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press_start();
    key_start_n = 1'b0;
    tick(12);
    key_start_n = 1'b1;
    tick(12);
  endtask

  task automatic press_page();
    key_page_n = 1'b0;
    tick(12);
    key_page_n = 1'b1;
    tick(12);
  endtask

  int base_req;
  int base_vc;
  int base_stall;

  initial begin
    // Reset state
    tick(3);
    chk("rst_valid", 32'(gcd_input_valid), 32'd0);
    chk("rst_bits_x", gcd_input_bits_x, 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset_n = 1'b1;
    tick(2);
    chk("idle_led", 32'(led), 32'd0);

    // 48,18 with ready delayed 3 cycles -> gcd 6
    eng_ready_delay = 3; eng_latency = 2; eng_respond = 1'b1;
    base_req = n_req; base_vc = n_valid_cyc; base_stall = n_stall;
    op_x = 8'd48; op_y = 8'd18;
    press_start();
    chk("hs_count", 32'(n_req - base_req), 32'd1);
    chk("hs_stall", 32'(n_stall - base_stall), 32'd3);
    chk("hs_valid_cyc", 32'(n_valid_cyc - base_vc), 32'd4);
    chk("hs_stable", 32'(n_unstable), 32'd0);
    chk("hs_x", got_x, 32'd48);
    chk("hs_y", got_y, 32'd18);
    chk("r48_led", 32'(led), 32'h6);
    chk("r48_busy", 32'(busy), 32'd0);
    chk("r48_err", 32'(err), 32'd0);
    press_page();
    chk("r48_pg1", 32'(led), 32'h0);
    press_page();
    chk("r48_pg0", 32'(led), 32'h6);

    // Bouncing start key -> one request, 12,8 -> 4
    eng_ready_delay = 0;
    base_req = n_req;
    op_x = 8'd12; op_y = 8'd8;
    key_start_n = 1'b0; tick(1);
    key_start_n = 1'b1; tick(1);
    key_start_n = 1'b0; tick(1);
    press_start();
    chk("bounce_req", 32'(n_req - base_req), 32'd1);
    chk("bounce_led", 32'(led), 32'h4);

    // 0xF0,0xF0 -> 0xF0, paging with wrap
    op_x = 8'hF0; op_y = 8'hF0;
    press_start();
    chk("f0_pg0", 32'(led), 32'h0);
    press_page();
    chk("f0_pg1", 32'(led), 32'hF);
    press_page();
    chk("f0_wrap", 32'(led), 32'h0);

    // One zero operand -> no request
    base_req = n_req; base_vc = n_valid_cyc;
    op_x = 8'd0; op_y = 8'd9;
    press_start();
    chk("z1_novalid", 32'(n_valid_cyc - base_vc), 32'd0);
    chk("z1_led", 32'(led), 32'h9);
    chk("z1_err", 32'(err), 32'd0);
    chk("z1_busy", 32'(busy), 32'd0);

    // Both zero -> err, all-ones LEDs regardless of page
    op_x = 8'd0; op_y = 8'd0;
    press_start();
    chk("z2_err", 32'(err), 32'd1);
    chk("z2_led", 32'(led), 32'hF);
    press_page();
    chk("z2_led_pg", 32'(led), 32'hF);
    chk("z2_novalid", 32'(n_valid_cyc - base_vc), 32'd0);

    // Start press during WAIT is ignored; 21,14 -> 7
    eng_latency = 40;
    base_req = n_req;
    op_x = 8'd21; op_y = 8'd14;
    press_start();
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_err_clr", 32'(err), 32'd0);
    op_x = 8'd10; op_y = 8'd5;
    press_start();
    tick(10);
    chk("wait_req", 32'(n_req - base_req), 32'd1);
    chk("wait_led", 32'(led), 32'h7);
    chk("wait_done", 32'(busy), 32'd0);

    // Asynchronous reset while WAIT; late engine result must be ignored
    eng_latency = 30;
    op_x = 8'd9; op_y = 8'd6;
    press_start();
    chk("ar_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", 32'(gcd_input_valid), 32'd0);
    chk("ar_busy0", 32'(busy), 32'd0);
    chk("ar_led", 32'(led), 32'd0);
    chk("ar_err", 32'(err), 32'd0);
    chk("ar_bits_y", gcd_input_bits_y, 32'd0);
    @(negedge clock);
    tick(2);
    reset_n = 1'b1;
    tick(20);
    chk("ar_late_led", 32'(led), 32'd0);
    chk("ar_late_busy", 32'(busy), 32'd0);

    // Engine never responds
    eng_respond = 1'b0; eng_latency = 0;
    op_x = 8'd9; op_y = 8'd6;
    press_start();
    tick(10);
`ifdef GCD_HARNESS_TIMEOUT_EN
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_led", 32'(led), 32'hF);
    chk("tmo_busy", 32'(busy), 32'd0);
`else
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_err", 32'(err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
